// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits 1/2/4-byte requests into byte strobes,
// assembles load data little-endian and extends it, stalling the pipe until done_o.
module load_store_unit #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_rdata_i
);

  // IDLE wait req | XFER one byte per cycle | LAST final load byte | DONE pulse
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_DONE} state_t;

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mis;
  logic [1:0]  r_cnt;
  logic        r_cap_en;
  logic [1:0]  r_cap_idx;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;

  logic        w_mis_in;
  logic [1:0]  w_last_idx;
  logic [7:0]  w_wbyte;
  logic [31:0] w_asm;
  logic [31:0] w_ext;

  always_comb begin
    case (size_i)
      2'b00:   w_mis_in = 1'b0;
      2'b01:   w_mis_in = addr_i[0];
      2'b10:   w_mis_in = |addr_i[1:0];
      default: w_mis_in = 1'b1;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_last_idx = 2'd0;
      2'b01:   w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  always_comb begin
    case (r_cnt)
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  // Read data arrives one cycle after its strobe, so merge it into the byte issued last cycle
  always_comb begin
    w_asm = r_buf;
    case (r_cap_idx)
      2'd0:    w_asm[7:0]   = mem_rdata_i;
      2'd1:    w_asm[15:8]  = mem_rdata_i;
      2'd2:    w_asm[23:16] = mem_rdata_i;
      default: w_asm[31:24] = mem_rdata_i;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_ext = r_sext ? {{24{w_asm[7]}}, w_asm[7:0]} : {24'd0, w_asm[7:0]};
      2'b01:   w_ext = r_sext ? {{16{w_asm[15]}}, w_asm[15:0]} : {16'd0, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 8'd0;
    done_o      = 1'b0;
    misalign_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) w_next = w_mis_in ? S_DONE : S_XFER;
      end
      S_XFER: begin
        mem_we_o    = r_we;
        mem_re_o    = ~r_we;
        mem_addr_o  = (r_addr + {30'd0, r_cnt}) & ADDR_MASK;
        mem_wdata_o = r_we ? w_wbyte : 8'd0;
        if (r_cnt == w_last_idx) w_next = r_we ? S_DONE : S_LAST;
      end
      S_LAST: w_next = S_DONE;
      default: begin
        done_o     = 1'b1;
        misalign_o = r_mis;
        w_next     = S_IDLE;
      end
    endcase
  end

  assign busy_o  = ((r_state != S_IDLE) | req_i) & ~done_o;
  assign rdata_o = r_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_sext    <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_mis     <= 1'b0;
      r_cnt     <= 2'd0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= 2'd0;
      r_buf     <= 32'd0;
      r_rdata   <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_cap_en  <= (r_state == S_XFER) & ~r_we;
      r_cap_idx <= r_cnt;
      if (r_cap_en) r_buf <= w_asm;
      if (r_state == S_IDLE && req_i) begin
        r_we    <= we_i;
        r_size  <= size_i;
        r_sext  <= sext_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_mis   <= w_mis_in;
        r_cnt   <= 2'd0;
      end
      if (r_state == S_XFER) r_cnt <= r_cnt + 2'd1;
      if (r_state == S_LAST) r_rdata <= w_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts each
// transaction; a negedge monitor checks strobes, stall, completion and load data.
module tb_load_store_unit;
  localparam int MEM_BYTES = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_o, mem_addr_o;
  logic        done_o, busy_o, misalign_o, mem_we_o, mem_re_o;
  logic [7:0]  mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size), .sext_i(sext),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_o), .done_o(done_o), .busy_o(busy_o),
    .misalign_o(misalign_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    bit          we;
    int          n;
    bit          mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] ref_last = 32'd0;
  bit          mem_init = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          scount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide memory: writes on the strobe edge, read data valid the next cycle
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
      mem_init <= 1'b1;
    end else if (mem_we_o) begin
      mem[mem_addr_o % MEM_BYTES] <= mem_wdata_o;
    end
    if (mem_re_o) mem_rdata_i <= mem[mem_addr_o % MEM_BYTES];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: operates on the byte array directly, at request time
  task automatic model(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, input int issue);
    exp_t e;
    logic [31:0] v;
    e.we = w; e.addr = a; e.wdata = wd; e.issue = issue;
    e.n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    e.lat = e.mis ? 1 : (w ? e.n + 1 : e.n + 2);
    if (!e.mis) begin
      if (w) begin
        for (int k = 0; k < e.n; k++) ref_mem[(a + k) % MEM_BYTES] = 8'((wd >> (8 * k)) & 32'hFF);
      end else begin
        v = 32'd0;
        for (int k = 0; k < e.n; k++) v = v + (32'(ref_mem[(a + k) % MEM_BYTES]) << (8 * k));
        if (sx && e.n < 4 && v >= (32'd1 << (8 * e.n - 1))) v = v - (32'd1 << (8 * e.n));
        ref_last = v;
      end
    end
    e.rdata = ref_last;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   k;
    bit   bexp;
    if (rst) begin
      scount = 0;
    end else begin
      bexp = (q.size() > 0) && (cyc >= q[0].issue) && (cyc < q[0].issue + q[0].lat);
      chk("busy", busy_o, bexp);
      chk("strobe_excl", mem_we_o & mem_re_o, 0);
      if (mem_we_o || mem_re_o) begin
        if (q.size() == 0) begin
          chk("stray_strobe", 1, 0);
        end else begin
          k = cyc - q[0].issue - 1;
          chk("strobe_slot", (k >= 0 && k < q[0].n && !q[0].mis), 1);
          chk("strobe_we", mem_we_o, q[0].we);
          chk("mem_addr", mem_addr_o, 32'((q[0].addr + k) % MEM_BYTES));
          if (q[0].we) chk("mem_wdata", mem_wdata_o, (q[0].wdata >> (8 * k)) & 32'hFF);
          scount++;
        end
      end else begin
        chk("idle_addr", mem_addr_o, 0);
        chk("idle_wdata", mem_wdata_o, 0);
      end
      if (done_o) begin
        if (q.size() == 0) begin
          chk("stray_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.issue, e.lat);
          chk("misalign", misalign_o, e.mis);
          chk("strobe_count", scount, e.mis ? 0 : e.n);
          chk("rdata", rdata_o, e.rdata);
        end
        scount = 0;
      end else begin
        chk("misalign_idle", misalign_o, 0);
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit b2b);
    if (!b2b) begin @(posedge clk); #2; end
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    model(w, sz, sx, a, wd, b2b ? cyc + 1 : cyc);
    if (b2b) begin @(posedge clk); #2; end
    @(posedge clk); #2;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_o && t < 40) begin @(posedge clk); #2; t++; end
    chk("done_timeout", done_o, 1);
    if (!done_o) q.delete();
  endtask

  initial begin
    logic [7:0]  old2, old3;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    #1;
    chk("rst_rdata", rdata_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_strobes", {mem_we_o, mem_re_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    issue(1, 2'd2, 0, 32'd8, 32'hDEADBEEF, 0); wait_done();
    issue(0, 2'd2, 0, 32'd8, 32'd0, 0);        wait_done();
    chk("T2_lw", rdata_o, 32'hDEADBEEF);
    issue(0, 2'd0, 1, 32'd11, 32'd0, 0);       wait_done();
    chk("T3_lb", rdata_o, 32'hFFFFFFDE);
    issue(0, 2'd0, 0, 32'd11, 32'd0, 0);       wait_done();
    chk("T3_lbu", rdata_o, 32'h000000DE);
    issue(0, 2'd1, 1, 32'd10, 32'd0, 0);       wait_done();
    chk("T3_lh", rdata_o, 32'hFFFFDEAD);
    issue(0, 2'd2, 0, 32'd6, 32'd0, 0);        wait_done();
    issue(1, 2'd1, 0, 32'd3, 32'h5555, 0);     wait_done();
    issue(0, 2'd3, 1, 32'd0, 32'd0, 0);        wait_done();
    chk("T4_held", rdata_o, 32'hFFFFDEAD);

    old2 = ref_mem[2]; old3 = ref_mem[3];
    issue(1, 2'd2, 0, 32'd0, 32'h11223344, 0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("T5_we", mem_we_o, 0);
    chk("T5_addr", mem_addr_o, 0);
    chk("T5_wdata", mem_wdata_o, 0);
    chk("T5_busy", busy_o, 0);
    chk("T5_rdata", rdata_o, 0);
    ref_mem[2] = old2; ref_mem[3] = old3;
    ref_last = 32'd0;
    q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    issue(0, 2'd2, 0, 32'd0, 32'd0, 0);        wait_done();
    chk("T5_lw", rdata_o, {old3, old2, 8'h33, 8'h44});

    issue(1, 2'd2, 0, 32'h28, 32'hCAFEF00D, 0); wait_done();
    issue(0, 2'd2, 0, 32'd8, 32'd0, 1);         wait_done();
    chk("T6_wrap", rdata_o, 32'hCAFEF00D);
    issue(0, 2'd1, 0, 32'h4A, 32'd0, 1);        wait_done();
    issue(1, 2'd3, 0, 32'd4, 32'd0, 1);         wait_done();

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
      wait_done();
    end

    @(posedge clk); @(posedge clk);
    for (int i = 0; i < MEM_BYTES; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end
endmodule
